video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the per-channel TMDS encoders in the HDMI transmit path.
- Free-running horizontal and vertical counters produce h_sync, v_sync, pixel-valid and pixel coordinates; these feed the encoders' sync/valid inputs and the pixel source.
- Defaults are 1280x720p60 on a 74.25 MHz pixel clock.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- H_SYNC_POL, 1, 1 = h_sync active-high, 0 = active-low
- V_SYNC_POL, 1, 1 = v_sync active-high, 0 = active-low
- CNT_W, 12, width of coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  asynchronous reset, active-high
- en_i  in  1  advance raster by one pixel per cycle when high
- h_sync_o  out  1  horizontal sync, polarity per H_SYNC_POL
- v_sync_o  out  1  vertical sync, polarity per V_SYNC_POL
- px_data_valid_o  out  1  current pixel is in the active area
- x_o  out  CNT_W  horizontal position of the emitted pixel
- y_o  out  CNT_W  vertical position of the emitted pixel
- line_start_o  out  1  one-cycle pulse at x=0 of every line
- frame_start_o  out  1  one-cycle pulse at (0,0)
- tp_r_o, tp_g_o, tp_b_o  out  8 each  test-pattern pixel (see Optional Feature)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise.
- Region order within both a line and a frame: active, front porch, sync, back porch.
- Internal counters h_cnt and v_cnt hold the next position to emit; both reset to 0.
- On each rising edge with en_i=1, all outputs register the decode of (h_cnt, v_cnt), then the counters advance:
  - h_cnt wraps H_TOTAL-1 -> 0;
  - v_cnt increments only on h wrap, and wraps V_TOTAL-1 -> 0 on the edge where both counters wrap.
- Latency: the first enabled edge after reset emits (0,0). Every later enabled edge emits the next raster position. No gaps.
- Decode:
  - px_data_valid = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE)
  - h_sync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines
  - v_sync active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines (toggles coincident with h_cnt=0)
  - x_o = h_cnt, y_o = v_cnt, for all positions including blanking
  - line_start = (h_cnt==0); frame_start = (h_cnt==0 and v_cnt==0)
- en_i=0:
  - counters hold;
  - h_sync_o, v_sync_o, x_o, y_o hold their last values;
  - px_data_valid_o, line_start_o, frame_start_o and tp_* are forced to 0 on that edge.
  - Resuming en_i emits the held next position. No pixel is skipped or repeated.
- Reset values:
  - h_sync_o = ~H_SYNC_POL, v_sync_o = ~V_SYNC_POL (inactive levels);
  - all other outputs 0.
- Reset mid-frame: asynchronous return to the reset values and to counter position (0,0). Raster restarts from the first enabled edge after release.
- Parameter checks: elaboration must fail if any parameter is 0 (polarities excepted) or if H_TOTAL/V_TOTAL exceed 2^CNT_W.

Optional Feature:
- Macro: VIDEO_TIMING_GEN_TEST_PATTERN_EN
- Defined: tp_r_o/tp_g_o/tp_b_o carry an 8-bar colour pattern, registered in the same cycle as px_data_valid_o.
  - bar = (h_cnt*8)/H_ACTIVE;
  - bars 0..7 = white, yellow, cyan, green, magenta, red, blue, black;
  - components are 0xFF or 0x00;
  - all three outputs are 0 whenever px_data_valid_o=0.
- Not defined: tp_* ports remain present and are tied to 0; no pattern logic is synthesised.

Test Plan:
- Small raster (H 4/1/2/1, V 3/1/1/1, both POL=1), en_i=1 after reset:
  - first enabled edge gives x=0, y=0, frame_start=1, line_start=1, valid=1;
  - valid is high for x 0..3 on y 0..2;
  - h_sync is high exactly at x=5,6 on every line;
  - v_sync is high for all 8 cycles of y=4;
  - frame_start recurs every 48 cycles.
- Same raster with H_SYNC_POL=0, V_SYNC_POL=0: reset levels are h_sync=1, v_sync=1; sync windows appear as low pulses at the same positions.
- en_i toggled 1,0,0,1 at x=2, y=1:
  - the two idle edges show valid=0 with x/y holding 2/1;
  - the next enabled edge emits x=3, y=1 with valid=1.
- rst_i asserted at x=6, y=4 (asynchronous, between edges):
  - outputs go to reset values immediately, without waiting for a clock edge;
  - after release, the first enabled edge emits (0,0) with frame_start=1.
- Default 720p parameters over 2 frames: 1650 cycles per line, 1,237,500 per frame; exactly 921,600 valid cycles per frame; v_sync high for 8250 consecutive cycles.
- With VIDEO_TIMING_GEN_TEST_PATTERN_EN, H_ACTIVE=16:
  - x=0,1 gives FF/FF/FF; x=2,3 gives FF/FF/00; x=14,15 gives 00/00/00;
  - blanking gives 0.
  - Without the macro, tp_* stay 0 throughout.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters decoded into syncs, valid, coordinates and start pulses.
// Optional colour-bar test pattern on tp_* when VIDEO_TIMING_GEN_TEST_PATTERN_EN is defined.
module video_timing_gen #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter bit H_SYNC_POL = 1'b1,
  parameter bit V_SYNC_POL = 1'b1,
  parameter int CNT_W      = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             h_sync_o,
  output logic             v_sync_o,
  output logic             px_data_valid_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             line_start_o,
  output logic             frame_start_o,
  output logic [7:0]       tp_r_o,
  output logic [7:0]       tp_g_o,
  output logic [7:0]       tp_b_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || CNT_W == 0) begin : g_zero_param
    $error("video_timing_gen: timing parameters and CNT_W must be non-zero");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_width_param
    $error("video_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic             h_sync;
    logic             v_sync;
    logic             valid;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;
  } out_t;

  logic [CNT_W-1:0] h_cnt_d, h_cnt_q, v_cnt_d, v_cnt_q;
  out_t             out_d, out_q;

  // NOTE: every path starts from a default so no signal can hold through a latch.
  always_comb begin
    h_cnt_d           = h_cnt_q;
    v_cnt_d           = v_cnt_q;
    out_d             = out_q;
    out_d.valid       = 1'b0;
    out_d.line_start  = 1'b0;
    out_d.frame_start = 1'b0;
    if (en_i) begin
      out_d.valid       = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      out_d.h_sync      = ((h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E)) ? H_SYNC_POL : ~H_SYNC_POL;
      out_d.v_sync      = ((v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E)) ? V_SYNC_POL : ~V_SYNC_POL;
      out_d.x           = h_cnt_q;
      out_d.y           = v_cnt_q;
      out_d.line_start  = (h_cnt_q == '0);
      out_d.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; syncs reset to their inactive level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      out_q        <= '0;
      out_q.h_sync <= ~H_SYNC_POL;
      out_q.v_sync <= ~V_SYNC_POL;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      out_q   <= out_d;
    end
  end

  assign h_sync_o        = out_q.h_sync;
  assign v_sync_o        = out_q.v_sync;
  assign px_data_valid_o = out_q.valid;
  assign x_o             = out_q.x;
  assign y_o             = out_q.y;
  assign line_start_o    = out_q.line_start;
  assign frame_start_o   = out_q.frame_start;

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  logic [2:0]  bar;
  logic [23:0] tp_d, tp_q;

  // Bar index counts how many of the 7 bar boundaries h_cnt*8 has reached, avoiding a divider.
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if ({h_cnt_q, 3'b000} >= (CNT_W+3)'(k * H_ACTIVE)) bar = bar + 3'd1;
    end
    tp_d = '0;
    if (out_d.valid) tp_d = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tp_q <= '0;
    else       tp_q <= tp_d;
  end

  assign {tp_r_o, tp_g_o, tp_b_o} = tp_q;
`else
  assign tp_r_o = '0;
  assign tp_g_o = '0;
  assign tp_b_o = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: four parameterisations driven by one clock/reset/enable,
// each checked against a linear-pixel-index raster model.
module tb_video_timing_gen;

  localparam int HA [4] = '{4, 4, 16, 1280};
  localparam int HF [4] = '{1, 1, 1, 110};
  localparam int HS [4] = '{2, 2, 2, 40};
  localparam int HB [4] = '{1, 1, 1, 220};
  localparam int VA [4] = '{3, 3, 3, 720};
  localparam int VF [4] = '{1, 1, 1, 5};
  localparam int VS [4] = '{1, 1, 1, 5};
  localparam int VB [4] = '{1, 1, 1, 20};
  localparam bit HP [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam bit VP [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        valid;
    logic [11:0] x;
    logic [11:0] y;
    logic        ls;
    logic        fs;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } obs_t;

  logic clk, rst, en;
  logic        hs_w [4], vs_w [4], dv_w [4], ls_w [4], fs_w [4];
  logic [11:0] x_w [4], y_w [4];
  logic [7:0]  red_w [4], grn_w [4], blu_w [4];
  obs_t        got [4];

  int   errors = 0;
  int   checks = 0;
  int   pos [4];
  obs_t expd [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    video_timing_gen #(
      .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
      .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
      .H_SYNC_POL(HP[g]), .V_SYNC_POL(VP[g]), .CNT_W(12)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .en_i(en),
      .h_sync_o(hs_w[g]), .v_sync_o(vs_w[g]), .px_data_valid_o(dv_w[g]),
      .x_o(x_w[g]), .y_o(y_w[g]), .line_start_o(ls_w[g]), .frame_start_o(fs_w[g]),
      .tp_r_o(red_w[g]), .tp_g_o(grn_w[g]), .tp_b_o(blu_w[g])
    );
    assign got[g] = {hs_w[g], vs_w[g], dv_w[g], x_w[g], y_w[g], ls_w[g], fs_w[g],
                     red_w[g], grn_w[g], blu_w[g]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int h_total(int k);
    return HA[k] + HF[k] + HS[k] + HB[k];
  endfunction

  function automatic int frame_len(int k);
    return h_total(k) * (VA[k] + VF[k] + VS[k] + VB[k]);
  endfunction

  function automatic obs_t reset_val(int k);
    obs_t o = '0;
    o.hs = !HP[k];
    o.vs = !VP[k];
    return o;
  endfunction

  // Expected outputs for pixel p of the frame, counted in raster order from (0,0).
  function automatic obs_t decode(int k, int p);
    obs_t o = '0;
    int h = p % h_total(k);
    int v = p / h_total(k);
    o.valid = (h < HA[k]) && (v < VA[k]);
    o.hs    = (h >= HA[k] + HF[k] && h < HA[k] + HF[k] + HS[k]) ? HP[k] : !HP[k];
    o.vs    = (v >= VA[k] + VF[k] && v < VA[k] + VF[k] + VS[k]) ? VP[k] : !VP[k];
    o.x     = 12'(h);
    o.y     = 12'(v);
    o.ls    = (h == 0);
    o.fs    = (p == 0);
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
    if (o.valid) begin
      case ((h * 8) / HA[k])
        0: {o.r, o.g, o.b} = 24'hFFFFFF;
        1: {o.r, o.g, o.b} = 24'hFFFF00;
        2: {o.r, o.g, o.b} = 24'h00FFFF;
        3: {o.r, o.g, o.b} = 24'h00FF00;
        4: {o.r, o.g, o.b} = 24'hFF00FF;
        5: {o.r, o.g, o.b} = 24'hFF0000;
        6: {o.r, o.g, o.b} = 24'h0000FF;
        default: {o.r, o.g, o.b} = 24'h000000;
      endcase
    end
`endif
    return o;
  endfunction

  // One clock edge; the model follows the inputs that were stable at that edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        pos[k]  = 0;
        expd[k] = reset_val(k);
      end else if (en) begin
        expd[k] = decode(k, pos[k]);
        pos[k]  = (pos[k] + 1) % frame_len(k);
      end else begin
        expd[k].valid = 1'b0;
        expd[k].ls    = 1'b0;
        expd[k].fs    = 1'b0;
        expd[k].r     = '0;
        expd[k].g     = '0;
        expd[k].b     = '0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== expd[k]) begin
        errors++;
        $display("FAIL reset dut%0d got=%h exp=%h", k, got[k], expd[k]);
      end
    end
    checks++;
    if (got[1].hs !== 1'b1 || got[1].vs !== 1'b1 || got[0].hs !== 1'b0 || got[0].vs !== 1'b0) begin
      errors++;
      $display("FAIL reset_sync_levels got pos=%b%b neg=%b%b exp pos=00 neg=11",
               got[0].hs, got[0].vs, got[1].hs, got[1].vs);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_edge();
    en = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== expd[k]) begin
        errors++;
        $display("FAIL first_edge dut%0d got=%h exp=%h", k, got[k], expd[k]);
      end
    end
    checks++;
    if (got[0].x !== 12'd0 || got[0].y !== 12'd0 || got[0].fs !== 1'b1 ||
        got[0].ls !== 1'b1 || got[0].valid !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_origin got x=%0d y=%0d fs=%b ls=%b v=%b exp 0 0 1 1 1",
               got[0].x, got[0].y, got[0].fs, got[0].ls, got[0].valid);
    end
  endtask

  task automatic test_small_frame();
    int n_valid = 0, n_vs = 0, n_hs = 0, n_hs_low = 0, n_fs = 0;
    int last_fs = -1, run = 0, max_run = 0;
    en = 1'b1;
    for (int i = 0; i < 96; i++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== expd[k]) begin
          errors++;
          $display("FAIL small_frame dut%0d cyc=%0d got=%h exp=%h", k, i, got[k], expd[k]);
        end
      end
      if (got[0].valid === 1'b1) n_valid++;
      if (got[0].hs === 1'b1) n_hs++;
      if (got[1].hs === 1'b0) n_hs_low++;
      if (got[0].vs === 1'b1) begin
        n_vs++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (got[0].fs === 1'b1) begin
        n_fs++;
        checks++;
        if (i - last_fs != 48) begin
          errors++;
          $display("FAIL frame_period got=%0d exp=48", i - last_fs);
        end
        last_fs = i;
      end
    end
    checks++;
    if (n_valid != 24 || n_hs != 24 || n_hs_low != 24 || n_vs != 16 || max_run != 8 || n_fs != 2) begin
      errors++;
      $display("FAIL small_frame_counts got valid=%0d hs=%0d hs_low=%0d vs=%0d run=%0d fs=%0d exp 24 24 24 16 8 2",
               n_valid, n_hs, n_hs_low, n_vs, max_run, n_fs);
    end
  endtask

  task automatic test_enable_gap();
    int guard = 0;
    en = 1'b1;
    while (pos[0] != 10 && guard < 200) begin
      tick();
      guard++;
    end
    checks++;
    if (pos[0] != 10) begin
      errors++;
      $display("FAIL enable_gap_reach got pos=%0d exp=10", pos[0]);
    end
    for (int s = 0; s < 4; s++) begin
      en = (s == 0 || s == 3);
      tick();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== expd[k]) begin
          errors++;
          $display("FAIL enable_gap dut%0d step=%0d got=%h exp=%h", k, s, got[k], expd[k]);
        end
      end
      checks++;
      if (got[0].x !== ((s == 3) ? 12'd3 : 12'd2) || got[0].y !== 12'd1 ||
          got[0].valid !== (s == 0 || s == 3)) begin
        errors++;
        $display("FAIL enable_gap_pos step=%0d got x=%0d y=%0d v=%b", s, got[0].x, got[0].y, got[0].valid);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    en = 1'b1;
    while (pos[0] != 38 && guard < 200) begin
      tick();
      guard++;
    end
    tick();
    checks++;
    if (got[0].x !== 12'd6 || got[0].y !== 12'd4 || got[0].hs !== 1'b1 || got[0].vs !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pos got x=%0d y=%0d hs=%b vs=%b exp 6 4 1 1",
               got[0].x, got[0].y, got[0].hs, got[0].vs);
    end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== reset_val(k)) begin
        errors++;
        $display("FAIL async_reset dut%0d got=%h exp=%h", k, got[k], reset_val(k));
      end
      pos[k]  = 0;
      expd[k] = reset_val(k);
    end
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== expd[k]) begin
        errors++;
        $display("FAIL post_reset dut%0d got=%h exp=%h", k, got[k], expd[k]);
      end
    end
    checks++;
    if (got[0].fs !== 1'b1 || got[0].x !== 12'd0 || got[0].y !== 12'd0) begin
      errors++;
      $display("FAIL post_reset_origin got fs=%b x=%0d y=%0d exp 1 0 0", got[0].fs, got[0].x, got[0].y);
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 3) != 0);
      tick();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== expd[k]) begin
          errors++;
          $display("FAIL random_enable dut%0d cyc=%0d got=%h exp=%h", k, i, got[k], expd[k]);
        end
      end
    end
  endtask

  task automatic test_default_lines();
    int n_valid = 0, n_hs = 0, n_ls = 0, n_vs = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 3300; i++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== expd[k]) begin
          errors++;
          $display("FAIL default_lines dut%0d cyc=%0d got=%h exp=%h", k, i, got[k], expd[k]);
        end
      end
      if (got[3].valid === 1'b1) n_valid++;
      if (got[3].hs === 1'b1) n_hs++;
      if (got[3].ls === 1'b1) n_ls++;
      if (got[3].vs === 1'b1) n_vs++;
    end
    checks++;
    if (n_valid != 2560 || n_hs != 80 || n_ls != 2 || n_vs != 0) begin
      errors++;
      $display("FAIL default_line_counts got valid=%0d hs=%0d ls=%0d vs=%0d exp 2560 80 2 0",
               n_valid, n_hs, n_ls, n_vs);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_first_edge();
    test_small_frame();
    test_enable_gap();
    test_async_reset();
    test_random_enable();
    test_default_lines();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
